axi_lite_regbank: RTL and testbench

//  Parametrised AXI4-Lite slave register bank; sensor controllers (ADXL345, etc.) use it as their CPU-facing register file.

---
 rtl/axi_lite_regbank.sv | 126 ++++++++++++
 tb/tb_axi_lite_regbank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave register file with RO masking, SLVERR, fabric update path and access strobes.
module axi_lite_regbank #(
  parameter int                   N_REGS      = 16,
  parameter int                   ADDR_WIDTH  = 6,
  parameter logic [N_REGS-1:0]    RO_MASK     = '0,
  parameter logic [N_REGS*32-1:0] RESET_VALUE = '0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [ADDR_WIDTH-1:0]  awaddr,
  input  logic [2:0]             awprot,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [ADDR_WIDTH-1:0]  araddr,
  input  logic [2:0]             arprot,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic [N_REGS-1:0]      hw_wr_en,
  input  logic [N_REGS*32-1:0]   hw_wr_data,
  output logic [N_REGS*32-1:0]   reg_out,
  output logic [N_REGS-1:0]      reg_wr_pulse,
  output logic [N_REGS-1:0]      reg_rd_pulse
);
  localparam int IW = ADDR_WIDTH - 2;
  logic [31:0]       r_regs [N_REGS];
  logic              r_aw_full, r_w_full, r_bvalid, r_rvalid;
  logic [IW-1:0]     r_aw_idx;
  logic [31:0]       r_wdata, r_rdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp, r_rresp;
  logic [N_REGS-1:0] r_wr_pulse, r_rd_pulse;
  logic [N_REGS-1:0] w_aw_hit, w_ar_hit, w_wr_sel;
  logic [31:0]       w_rd_val, w_strb_mask;
  logic [31:0]       w_next [N_REGS];
  logic              w_commit, w_ar_hs, w_unused;
  assign w_unused    = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
  assign awready     = !r_aw_full && !r_bvalid;
  assign wready      = !r_w_full && !r_bvalid;
  assign arready     = !r_rvalid;
  assign bvalid      = r_bvalid;
  assign bresp       = r_bresp;
  assign rvalid      = r_rvalid;
  assign rresp       = r_rresp;
  assign rdata       = r_rdata;
  assign reg_wr_pulse = r_wr_pulse;
  assign reg_rd_pulse = r_rd_pulse;
  assign w_commit    = r_aw_full && r_w_full && !r_bvalid;
  assign w_ar_hs     = arvalid && !r_rvalid;
  assign w_wr_sel    = w_commit ? (w_aw_hit & ~RO_MASK) : '0;
  assign w_strb_mask = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  // One-hot decode; indices at or above N_REGS match nothing and so read as out of range.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < N_REGS; i++) begin
      w_aw_hit[i] = r_aw_idx == IW'(i);
      w_ar_hit[i] = araddr[ADDR_WIDTH-1:2] == IW'(i);
      w_rd_val    = w_rd_val | (w_ar_hit[i] ? r_regs[i] : 32'h0);
    end
  end
  // Fabric data is the base; AXI-strobed bytes override it on a commit.
  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      w_next[i] = hw_wr_en[i] ? hw_wr_data[i*32+:32] : r_regs[i];
      w_next[i] = w_wr_sel[i] ? ((r_wdata & w_strb_mask) | (w_next[i] & ~w_strb_mask)) : w_next[i];
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= RESET_VALUE[i*32+:32];
      r_aw_full  <= 1'b0;
      r_w_full   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_rvalid   <= 1'b0;
      r_rresp    <= 2'b00;
      r_rdata    <= '0;
      r_wr_pulse <= '0;
      r_rd_pulse <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= w_next[i];
      if (awvalid && awready) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= awaddr[ADDR_WIDTH-1:2];
      end
      if (wvalid && wready) begin
        r_w_full <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= |w_wr_sel ? 2'b00 : 2'b10;
      end else if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
      r_wr_pulse <= w_wr_sel;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
        r_rresp  <= |w_ar_hit ? 2'b00 : 2'b10;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end
      r_rd_pulse <= w_ar_hs ? w_ar_hit : '0;
    end
  end
  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign reg_out[g*32+:32] = r_regs[g];
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: vector table, directed corner sequences and random traffic against an array model.
module tb_axi_lite_regbank;
  localparam int            NR = 12;
  localparam logic [NR-1:0] RO = 12'h001;
  localparam logic [NR*32-1:0] RV = {{10{32'h0}}, 32'h0000000A, 32'h0};
  logic aclk = 0, aresetn = 0;
  logic [5:0] awaddr = 0, araddr = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [NR-1:0] hw_wr_en = 0, reg_wr_pulse, reg_rd_pulse;
  logic [NR*32-1:0] hw_wr_data = 0, reg_out;
  int errors = 0, checks = 0;
  logic [31:0] m [NR];

  axi_lite_regbank #(.N_REGS(NR), .ADDR_WIDTH(6), .RO_MASK(RO), .RESET_VALUE(RV)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .hw_wr_en(hw_wr_en), .hw_wr_data(hw_wr_data), .reg_out(reg_out),
    .reg_wr_pulse(reg_wr_pulse), .reg_rd_pulse(reg_rd_pulse));

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m[i] = RV[i*32+:32];
  endfunction

  function automatic logic [1:0] m_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int i = int'(a[5:2]);
    if (i >= NR || RO[i]) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) m[i][b*8+:8] = d[b*8+:8];
    return 2'b00;
  endfunction

  function automatic logic [NR-1:0] onehot(input logic [5:0] a, input logic [1:0] resp);
    return resp == 2'b00 ? NR'(1) << a[5:2] : '0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [5:0] a);
    return int'(a[5:2]) < NR ? m[a[5:2]] : 32'h0;
  endfunction

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [NR-1:0] pulse);
    bit aw_hs, w_hs;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      step();
      if (aw_hs) awvalid = 0;
      if (w_hs) wvalid = 0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    resp = bresp;
    pulse = reg_wr_pulse;
    if (!bvalid) begin
      errors++; checks++;
      $display("FAIL write timeout: addr %h got no bvalid, required bvalid=1", a);
      awvalid = 0; wvalid = 0;
    end
    bready = 1; step(); bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic [NR-1:0] pulse);
    int n = 0;
    araddr = a; arvalid = 1; rready = 0;
    while (!arready && n < 50) begin step(); n++; end
    step(); arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    d = rdata; resp = rresp; pulse = reg_rd_pulse;
    if (!rvalid) begin
      errors++; checks++;
      $display("FAIL read timeout: addr %h got no rvalid, required rvalid=1", a);
    end
    rready = 1; step(); rready = 0;
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < NR; i++) check($sformatf("%s reg%0d", name, i), reg_out[i*32+:32], m[i]);
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdat;
  } vec_t;

  initial begin
    vec_t vt [12];
    logic [1:0] resp;
    logic [31:0] d;
    logic [NR-1:0] pulse;
    vt[0]  = '{0, 6'h04, 0, 0, 2'b00, 32'h0000000A};
    vt[1]  = '{0, 6'h00, 0, 0, 2'b00, 32'h00000000};
    vt[2]  = '{1, 6'h18, 32'h5A5A5A5A, 4'b1010, 2'b00, 0};
    vt[3]  = '{0, 6'h18, 0, 0, 2'b00, 32'h5A005A00};
    vt[4]  = '{1, 6'h00, 32'hFFFFFFFF, 4'b1111, 2'b10, 0};
    vt[5]  = '{0, 6'h00, 0, 0, 2'b00, 32'h00000000};
    vt[6]  = '{0, 6'h3C, 0, 0, 2'b10, 32'h00000000};
    vt[7]  = '{1, 6'h30, 32'h12345678, 4'b1111, 2'b10, 0};
    vt[8]  = '{1, 6'h06, 32'h12345678, 4'b1111, 2'b00, 0};
    vt[9]  = '{1, 6'h04, 32'hABCD0000, 4'b1100, 2'b00, 0};
    vt[10] = '{0, 6'h05, 0, 0, 2'b00, 32'hABCD5678};
    vt[11] = '{0, 6'h2C, 0, 0, 2'b00, 32'h00000000};

    m_reset();
    repeat (3) step();
    aresetn = 1;
    check("reset awready", awready, 1);
    check("reset wready", wready, 1);
    check("reset arready", arready, 1);
    check("reset bvalid", bvalid, 0);
    check("reset rvalid", rvalid, 0);
    check("reset pulses", {reg_wr_pulse, reg_rd_pulse}, 0);
    check_all("reset");

    // Simultaneous AW/W to reg2: latency, pulse width and bvalid hold.
    awaddr = 6'h08; wdata = 32'hA5A5A5A5; wstrb = 4'b0101; awvalid = 1; wvalid = 1;
    step(); awvalid = 0; wvalid = 0;
    check("lat bvalid early", bvalid, 0);
    step();
    check("lat bvalid", bvalid, 1);
    check("lat bresp", bresp, 2'b00);
    check("lat pulse", reg_wr_pulse, 12'h004);
    check("lat reg2", reg_out[2*32+:32], 32'h00A500A5);
    step();
    check("lat pulse width", reg_wr_pulse, 0);
    check("lat bvalid hold", bvalid, 1);
    bready = 1; step(); bready = 0;
    check("lat bvalid clr", bvalid, 0);
    void'(m_write(6'h08, 32'hA5A5A5A5, 4'b0101));

    foreach (vt[k]) begin
      if (vt[k].wr) begin
        axi_write(vt[k].addr, vt[k].data, vt[k].strb, resp, pulse);
        check($sformatf("vec%0d bresp", k), resp, vt[k].resp);
        check($sformatf("vec%0d wpulse", k), pulse, onehot(vt[k].addr, vt[k].resp));
        void'(m_write(vt[k].addr, vt[k].data, vt[k].strb));
      end else begin
        axi_read(vt[k].addr, d, resp, pulse);
        check($sformatf("vec%0d rresp", k), resp, vt[k].resp);
        check($sformatf("vec%0d rdata", k), d, vt[k].rdat);
        check($sformatf("vec%0d rpulse", k), pulse, onehot(vt[k].addr, vt[k].resp));
      end
    end
    check_all("table");

    // W three cycles ahead of AW, then B held off for five cycles.
    wdata = 32'hCAFEF00D; wstrb = 4'b1111; wvalid = 1;
    step(); wvalid = 0;
    check("ooo wready", wready, 0);
    check("ooo awready", awready, 1);
    step(); step();
    check("ooo no early b", bvalid, 0);
    awaddr = 6'h1C; awvalid = 1;
    step(); awvalid = 0;
    check("ooo b after aw", bvalid, 0);
    step();
    check("ooo bvalid", bvalid, 1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("ooo stall%0d", c), {bvalid, awready, wready}, 3'b100);
      step();
    end
    bready = 1; step(); bready = 0;
    check("ooo released", {bvalid, awready, wready}, 3'b011);
    step();
    check("ooo single b", bvalid, 0);
    void'(m_write(6'h1C, 32'hCAFEF00D, 4'b1111));
    check("ooo reg7", reg_out[7*32+:32], m[7]);

    // Fabric write and AXI commit to reg3 on the same edge.
    awaddr = 6'h0C; wdata = 32'hAABBCCDD; wstrb = 4'b0011; awvalid = 1; wvalid = 1;
    step(); awvalid = 0; wvalid = 0;
    hw_wr_en = 12'h008; hw_wr_data[3*32+:32] = 32'h11223344;
    step(); hw_wr_en = 0;
    check("merge reg3", reg_out[3*32+:32], 32'h1122CCDD);
    check("merge bresp", bresp, 2'b00);
    bready = 1; step(); bready = 0;
    m[3] = 32'h1122CCDD;

    // Fabric write into the AXI-read-only register.
    hw_wr_en = 12'h001; hw_wr_data[31:0] = 32'h0BADF00D;
    step(); hw_wr_en = 0;
    m[0] = 32'h0BADF00D;
    axi_read(6'h00, d, resp, pulse);
    check("ro hw rdata", d, 32'h0BADF00D);

    for (int it = 0; it < 60; it++) begin
      logic [5:0] a;
      logic [31:0] rd;
      logic [3:0] s;
      int op;
      a = 6'($urandom_range(0, 63));
      rd = $urandom;
      s = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 2);
      if (op == 0) begin
        axi_write(a, rd, s, resp, pulse);
        begin
          logic [1:0] er;
          er = m_write(a, rd, s);
          check($sformatf("rnd%0d bresp", it), resp, er);
          check($sformatf("rnd%0d wpulse", it), pulse, onehot(a, er));
        end
      end else if (op == 1) begin
        axi_read(a, d, resp, pulse);
        check($sformatf("rnd%0d rdata", it), d, m_rdata(a));
        check($sformatf("rnd%0d rresp", it), resp, int'(a[5:2]) < NR ? 2'b00 : 2'b10);
      end else begin
        int r = $urandom_range(0, NR - 1);
        hw_wr_en = NR'(1) << r; hw_wr_data[r*32+:32] = rd;
        step(); hw_wr_en = 0;
        m[r] = rd;
        check($sformatf("rnd%0d hw reg%0d", it, r), reg_out[r*32+:32], rd);
      end
    end
    check_all("random");

    // Reset with AW buffered and a read response pending.
    awaddr = 6'h08; awvalid = 1; araddr = 6'h04; arvalid = 1;
    step(); awvalid = 0; arvalid = 0;
    check("rst rvalid pending", rvalid, 1);
    aresetn = 0;
    step(); step();
    aresetn = 1;
    m_reset();
    check("rst bvalid", bvalid, 0);
    check("rst rvalid", rvalid, 0);
    check("rst readies", {awready, wready, arready}, 3'b111);
    check_all("rst");
    wdata = 32'hFFFFFFFF; wstrb = 4'b1111; wvalid = 1;
    step(); wvalid = 0;
    step(); step(); step();
    check("rst aw dropped", bvalid, 0);
    awaddr = 6'h14; awvalid = 1;
    step(); awvalid = 0;
    step();
    check("rst new commit", bvalid, 1);
    void'(m_write(6'h14, 32'hFFFFFFFF, 4'b1111));
    bready = 1; step(); bready = 0;
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
